// File: rtl/store_router_if.sv
`default_nettype none
// ============================================================================
// Module : store_router_if
// Brief  : LSU store request, data-memory write and peripheral drain bundle.
// Rev    : 1.0
// ============================================================================
interface store_router_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [2:0]  st_funct3;
    logic        st_stall;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        per_valid;
    logic        per_ready;
    logic [31:0] per_addr;
    logic [31:0] per_wdata;
    logic [3:0]  per_wmask;

    modport master (
        input  st_valid, st_addr, st_wdata, st_funct3, per_ready,
        output st_stall, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
               per_valid, per_addr, per_wdata, per_wmask
    );

    modport slave (
        output st_valid, st_addr, st_wdata, st_funct3, per_ready,
        input  st_stall, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
               per_valid, per_addr, per_wdata, per_wmask
    );
endinterface
`default_nettype wire

// File: rtl/store_router.sv
`default_nettype none
// ============================================================================
// Module : store_router
// Brief  : Store lane generation, DMEM/peripheral routing with write buffer,
//          and tohost capture.
// Rev    : 1.0
// ============================================================================
module store_router #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    store_router_if.master   bus,
    output logic [31:0]      tohost_value,
    output logic             tohost_done,
    output logic             misalign_err
);
    localparam int                 c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic                 w_legal;
    logic [3:0]           w_mask;
    logic [31:0]          w_data;
    logic [31:0]          w_waddr;
    logic                 w_per_sel;
    logic                 w_store;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_tohost_hit;

    logic [31:0]          r_fifo_addr [FIFO_DEPTH];
    logic [31:0]          r_fifo_data [FIFO_DEPTH];
    logic [3:0]           r_fifo_mask [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic [31:0]          r_tohost_value;
    logic                 r_tohost_done;
    logic                 r_misalign;

    always_comb begin
        w_legal = 1'b0;
        w_mask  = 4'b0000;
        w_data  = 32'h0;
        case (bus.st_funct3)
            3'b000: begin
                w_legal = 1'b1;
                w_mask  = 4'b0001 << bus.st_addr[1:0];
                w_data  = {4{bus.st_wdata[7:0]}};
            end
            3'b001: begin
                w_legal = ~bus.st_addr[0];
                w_mask  = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                w_data  = {2{bus.st_wdata[15:0]}};
            end
            3'b010: begin
                w_legal = (bus.st_addr[1:0] == 2'b00);
                w_mask  = 4'b1111;
                w_data  = bus.st_wdata;
            end
            default: ;
        endcase
    end

    assign w_waddr   = {bus.st_addr[31:2], 2'b00};
    assign w_per_sel = |bus.st_addr[16:8];
    assign w_store   = bus.st_valid & w_legal;
    // Full is judged on the start-of-cycle count, so a pop never frees a slot
    // for a push in the same cycle.
    assign w_full    = (r_count == c_depth);
    assign w_push    = w_store & w_per_sel & ~w_full;
    assign w_pop     = (r_count != '0) & bus.per_ready;
    assign w_tohost_hit = w_push & (w_waddr == TOHOST_ADDR);

    assign bus.st_stall   = w_store & w_per_sel & w_full;
    assign bus.dmem_we    = w_store & ~w_per_sel;
    assign bus.dmem_addr  = w_waddr;
    assign bus.dmem_wdata = w_data;
    assign bus.dmem_wmask = bus.dmem_we ? w_mask : 4'b0000;

    assign bus.per_valid  = (r_count != '0);
    assign bus.per_addr   = r_fifo_addr[r_rd_ptr];
    assign bus.per_wdata  = r_fifo_data[r_rd_ptr];
    assign bus.per_wmask  = r_fifo_mask[r_rd_ptr];

    assign tohost_value = r_tohost_value;
    assign tohost_done  = r_tohost_done;
    assign misalign_err = r_misalign;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_waddr;
            r_fifo_data[r_wr_ptr] <= w_data;
            r_fifo_mask[r_wr_ptr] <= w_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tohost_value <= 32'h0;
            r_tohost_done  <= 1'b0;
            r_misalign     <= 1'b0;
        end else begin
            r_misalign <= bus.st_valid & ~w_legal;
            if (w_tohost_hit) begin
                r_tohost_done <= 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (w_mask[i]) r_tohost_value[8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/store_router.md
Name: store_router

Overview:
- Write-side companion to the load-path return mux.
- Takes LSU store requests from the single-cycle core and generates byte-lane masks and aligned write data.
- Decodes the target region using the same rule as the load path: address bits [16:8] non-zero selects the peripheral/host region, otherwise data memory.
- Data-memory writes issue in the same cycle. Peripheral writes are buffered in a small FIFO and drained over a valid/ready port. Writes to the tohost word are captured for compliance-test termination.

Parameters:
- FIFO_DEPTH, 4: peripheral write buffer entries; power of two, at least 2.
- TOHOST_ADDR, 32'h0000_1000: word-aligned address of the tohost location; must decode as peripheral region.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- st_valid  input  1  store request this cycle
- st_addr  input  32  byte address of store
- st_wdata  input  32  rs2 value, right-justified
- st_funct3  input  3  000 SB, 001 SH, 010 SW; any other value is illegal
- st_stall  output  1  combinational; holds the core PC and register file this cycle
- dmem_we  output  1  data-memory write strobe, combinational
- dmem_addr  output  32  word-aligned address, {st_addr[31:2],2'b00}
- dmem_wdata  output  32  lane-replicated write data
- dmem_wmask  output  4  byte enables
- per_valid  output  1  FIFO head valid
- per_ready  input  1  peripheral accepts head
- per_addr  output  32  head word-aligned address
- per_wdata  output  32  head data
- per_wmask  output  4  head byte enables
- tohost_value  output  32  last value written to TOHOST_ADDR, merged by mask
- tohost_done  output  1  sticky; set once tohost is written
- misalign_err  output  1  one-cycle registered pulse on a dropped store

Behaviour:
- Lane generation (combinational):
  - SB: mask = 4'b0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - SH: mask = addr[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}.
  - SW: mask = 4'b1111; data = wdata.
- Illegal requests: SH with addr[0]=1, SW with addr[1:0]!=0, and any illegal funct3.
  - No write to either target and no stall.
  - misalign_err = 1 in the following cycle only.
- Region decode: per_sel = |st_addr[16:8].
- DMEM path: dmem_we = st_valid & legal & ~per_sel, in the same cycle. dmem_wmask = 0 when dmem_we = 0.
- Peripheral path:
  - Push when st_valid & legal & per_sel & ~full.
  - st_stall = st_valid & legal & per_sel & full.
  - Push is evaluated against the count at the start of the cycle. When full, a same-cycle pop does not admit a push; the store stalls one more cycle.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH, plus a count of width clog2(FIFO_DEPTH)+1.
  - per_valid = (count != 0). per_addr, per_wdata and per_wmask are driven from the head entry.
  - Pop when per_valid & per_ready.
  - Simultaneous push and pop when not full: count unchanged and both pointers advance.
  - per_addr/wdata/wmask are stable while per_valid=1 and per_ready=0.
- tohost:
  - Trigger: a legal accepted peripheral push with {st_addr[31:2],2'b00} == TOHOST_ADDR.
  - On the next edge, tohost_value is updated per byte lane from the lane data, and tohost_done is set.
  - tohost_done stays set until reset. The store is also pushed to the FIFO.
  - A stalled store to tohost does not update it until accepted.
- Reset (async assert, sync release):
  - Pointers and count = 0; per_valid = 0; tohost_value = 0; tohost_done = 0; misalign_err = 0.
  - Buffered entries are discarded, including on reset mid-drain.
  - Combinational outputs follow their inputs with an empty FIFO.
- Latency:
  - DMEM write: 0 cycles.
  - Peripheral head: per_valid rises 1 cycle after the push edge when the FIFO was empty.
  - tohost_done: 1 cycle.

Test Plan:
- SB to 0x0000_0043 with wdata 0x1234_56AB -> dmem_we=1, dmem_addr=0x40, dmem_wmask=4'b1000, dmem_wdata=0xABAB_ABAB, per_valid stays 0.
- SH to 0x0000_0102 with wdata 0xCAFE -> no DMEM write; next cycle per_valid=1, per_addr=0x100, per_wmask=4'b1100, per_wdata=0xCAFE_CAFE.
- per_ready=0, five consecutive SW to 0x200..0x210 (FIFO_DEPTH=4) -> the first four are accepted. st_stall=1 on the fifth until per_ready=1 frees one entry (push is accepted the cycle after the pop). The drain order is 0x200, 0x204, 0x208, 0x20C, 0x210.
- SW 0x0000_0001 to 0x1000 -> tohost_value=1, tohost_done=1 one cycle later and stays 1. The entry also appears on the per_* port.
- SW to 0x0000_0042 and SH to 0x0000_0101 -> no dmem_we, no push, misalign_err pulses once per store, count unchanged.
- Fill FIFO with 3 entries, assert rst_n=0 mid-drain -> per_valid=0 and count=0 immediately. After release, a new store appears as the sole head.
